// File: rtl/seg7_score_display_pkg.sv
// Shared constants for the score display: segment patterns, display limit,
// converter state encoding and the BCD adjust step.
package seg7_score_display_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam int unsigned MAX_DISPLAY = 9999;

  typedef enum logic [1:0] {
    DISP_IDLE,
    DISP_CONV,
    DISP_COMMIT
  } disp_state_t;

  // Double-dabble correction: add 3 to every nibble that is 5 or more.
  function automatic logic [15:0] bcd_adjust(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int unsigned i = 0; i < 4; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_score_display_bin_to_bcd.sv
// Free-running sequential binary-to-BCD converter: capture, shift CONV_BITS
// times, then present the result for one COMMIT cycle.
module bin_to_bcd
  import seg7_score_display_pkg::*;
#(
  parameter int unsigned CONV_BITS = 14
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [CONV_BITS-1:0] bin,
  output logic [15:0]          bcd,
  output logic                 ovf,
  output logic                 busy,
  output logic                 done
);

  localparam logic [3:0] LAST = 4'(CONV_BITS - 1);

  disp_state_t          state, state_next;
  logic [3:0]           cnt;
  logic [15:0]          acc;
  logic [CONV_BITS-1:0] shift_bin;
  logic                 ovf_cap;

  always_comb begin
    state_next = state;
    case (state)
      DISP_IDLE:   state_next = DISP_CONV;
      DISP_CONV:   if (cnt == LAST) state_next = DISP_COMMIT;
      DISP_COMMIT: state_next = DISP_IDLE;
      default:     state_next = DISP_IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up with state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= DISP_IDLE;
      cnt       <= '0;
      acc       <= '0;
      shift_bin <= '0;
      ovf_cap   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != DISP_IDLE);
      done  <= (state_next == DISP_COMMIT);
      case (state)
        DISP_IDLE: begin
          shift_bin <= bin;
          acc       <= '0;
          cnt       <= '0;
          ovf_cap   <= (32'(bin) > MAX_DISPLAY);
        end
        DISP_CONV: begin
          {acc, shift_bin} <= {bcd_adjust(acc), shift_bin} << 1;
          cnt              <= cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign bcd = acc;
  assign ovf = ovf_cap;

endmodule

// File: rtl/seg7_score_display.sv
// Four-digit score display: holds the last committed BCD digits and scans
// them across an/seg with leading-zero blanking and overflow dashes.
module seg7_score_display
  import seg7_score_display_pkg::*;
#(
  parameter int unsigned CONV_BITS = 14
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 scan_tick,
  input  logic [CONV_BITS-1:0] value,
  input  logic                 blank,
  output logic [3:0]           an,
  output logic [6:0]           seg,
  output logic                 conv_busy
);

  logic [15:0]     bcd;
  logic            ovf, done;
  logic [3:0][3:0] digits;
  logic            ovf_q;
  logic [1:0]      idx;
  logic [3:0]      cur;
  logic            lz;
  logic [3:0]      an_next;
  logic [6:0]      seg_next;

  bin_to_bcd #(.CONV_BITS(CONV_BITS)) u_conv (
    .clk     (clk),
    .reset_n (reset_n),
    .bin     (value),
    .bcd     (bcd),
    .ovf     (ovf),
    .busy    (conv_busy),
    .done    (done)
  );

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction

  always_comb begin
    cur = digits[idx];
    lz  = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (i >= 32'(idx) && digits[i] != 4'd0) lz = 1'b0;
    end
    an_next = ~(4'b0001 << idx);
    if (ovf_q)                  seg_next = SEG_DASH;
    else if (idx != 2'd0 && lz) seg_next = SEG_BLANK;
    else                        seg_next = decode(cur);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      digits <= '0;
      ovf_q  <= 1'b0;
      idx    <= '0;
      an     <= '1;
      seg    <= '1;
    end else begin
      if (done) begin
        digits <= bcd;
        ovf_q  <= ovf;
      end
      if (scan_tick) idx <= idx + 2'd1;
      if (blank) begin
        an  <= '1;
        seg <= SEG_BLANK;
      end else if (scan_tick) begin
        an  <= an_next;
        seg <= seg_next;
      end
    end
  end

endmodule
